// File: rtl/posit_lut_func_pipe.sv
// Purpose : runtime-loadable, multi-table posit unary-function lookup (ln, exp, recip, ...).
// Latency : lookup accepted at edge N is presented on out_* after edge N+1, consumed at edge N+2.
// Backpr. : out_valid && !out_ready freezes S0, S1 and the RAM read; in_ready drops in that cycle.
//
// Ports:
//   clock, resetn                      single clock, async active-low reset
//   in_valid/in_ready, in_func/in_data lookup request (in_data is the table address)
//   out_valid/out_ready, out_data/func lookup result and the table that produced it
//   load_valid, load_func/addr/data    table write port, accepted every cycle
//   func_loaded                        sticky per table, set when its last entry is written
module posit_lut_func_pipe #(
  parameter int WIDTH     = 8,
  parameter int ES        = 1,
  parameter int NUM_FUNCS = 4,
  localparam int FW       = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FW-1:0]        in_func,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [FW-1:0]        out_func,
  input  logic                 load_valid,
  input  logic [FW-1:0]        load_func,
  input  logic [WIDTH-1:0]     load_addr,
  input  logic [WIDTH-1:0]     load_data,
  output logic [NUM_FUNCS-1:0] func_loaded
);

  localparam int               DEPTH     = 1 << WIDTH;
  localparam logic [WIDTH-1:0] NAR       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LAST_ADDR = {WIDTH{1'b1}};

  // The exponent size does not change the NaR/zero encodings, but a posit
  // needs room for sign, at least one regime bit and the exponent field.
  if (ES < 0 || ES > WIDTH - 2) begin : g_es_range
    $error("posit_lut_func_pipe: ES out of range for WIDTH");
  end

  logic [WIDTH-1:0] mem [NUM_FUNCS][DEPTH];

  logic                 ready_q, ready_d;
  logic                 s0_vld_q, s0_vld_d;
  logic [FW-1:0]        s0_func_q, s0_func_d;
  logic [WIDTH-1:0]     s0_data_q, s0_data_d;
  logic                 s0_nar_q, s0_nar_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [FW-1:0]        s1_func_q, s1_func_d;
  logic [WIDTH-1:0]     s1_data_q, s1_data_d;
  logic                 ld_vld_q, ld_vld_d;
  logic [FW-1:0]        ld_func_q, ld_func_d;
  logic [WIDTH-1:0]     ld_addr_q, ld_addr_d;
  logic [WIDTH-1:0]     ld_data_q, ld_data_d;
  logic [NUM_FUNCS-1:0] func_loaded_q, func_loaded_d;

  logic                 stall;
  logic [FW-1:0]        rd_func;
  logic [WIDTH-1:0]     rd_data;

  always_comb begin
    stall         = s1_vld_q && !out_ready;
    in_ready      = ready_q && !stall;

    // Out-of-range selects never index the RAM; their result is forced to NaR anyway.
    rd_func       = s0_nar_q ? '0 : s0_func_q;
    rd_data       = mem[rd_func][s0_data_q];

    ready_d       = 1'b1;
    s0_vld_d      = s0_vld_q;
    s0_func_d     = s0_func_q;
    s0_data_d     = s0_data_q;
    s0_nar_d      = s0_nar_q;
    s1_vld_d      = s1_vld_q;
    s1_func_d     = s1_func_q;
    s1_data_d     = s1_data_q;
    func_loaded_d = func_loaded_q;

    // Writes are registered once before committing. A lookup accepted in the
    // same cycle as a write reads the RAM on the very edge the write commits,
    // so it sees the old entry; any later lookup sees the new one.
    ld_vld_d      = load_valid && (int'(load_func) < NUM_FUNCS);
    ld_func_d     = load_func;
    ld_addr_d     = load_addr;
    ld_data_d     = load_data;

    // Whole pipe (including empty slots) advances together or not at all.
    if (!stall) begin
      s0_vld_d = in_valid && in_ready;
      if (in_valid && in_ready) begin
        s0_func_d = in_func;
        s0_data_d = in_data;
        s0_nar_d  = (in_data == NAR) || (int'(in_func) >= NUM_FUNCS);
      end
      s1_vld_d = s0_vld_q;
      if (s0_vld_q) begin
        s1_func_d = s0_func_q;
        s1_data_d = s0_nar_q ? NAR : rd_data;
      end
    end

    for (int f = 0; f < NUM_FUNCS; f++) begin
      if (ld_vld_q && (ld_addr_q == LAST_ADDR) && (int'(ld_func_q) == f)) begin
        func_loaded_d[f] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_q       <= 1'b0;
      s0_vld_q      <= 1'b0;
      s0_func_q     <= '0;
      s0_data_q     <= '0;
      s0_nar_q      <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_func_q     <= '0;
      s1_data_q     <= '0;
      ld_vld_q      <= 1'b0;
      ld_func_q     <= '0;
      ld_addr_q     <= '0;
      ld_data_q     <= '0;
      func_loaded_q <= '0;
    end else begin
      ready_q       <= ready_d;
      s0_vld_q      <= s0_vld_d;
      s0_func_q     <= s0_func_d;
      s0_data_q     <= s0_data_d;
      s0_nar_q      <= s0_nar_d;
      s1_vld_q      <= s1_vld_d;
      s1_func_q     <= s1_func_d;
      s1_data_q     <= s1_data_d;
      ld_vld_q      <= ld_vld_d;
      ld_func_q     <= ld_func_d;
      ld_addr_q     <= ld_addr_d;
      ld_data_q     <= ld_data_d;
      func_loaded_q <= func_loaded_d;
    end
  end

  // Table storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (ld_vld_q) begin
      mem[ld_func_q][ld_addr_q] <= ld_data_q;
    end
  end

  assign out_valid   = s1_vld_q;
  assign out_data    = s1_data_q;
  assign out_func    = s1_func_q;
  assign func_loaded = func_loaded_q;

endmodule

// File: doc/posit_lut_func_pipe.md
# posit_lut_func_pipe

Pipelined, multi-function posit unary-function unit: each of NUM_FUNCS tables holds one 2^WIDTH-entry posit-to-posit map (ln, exp, recip, sigmoid, …). Tables are loaded at runtime through a write port. Lookups stream through a valid/ready pipeline at one result per cycle. It replaces the fixed single-function, combinational, file-initialised LUT wrappers in the posit datapath, where a unary function result is needed between accumulate and requantise stages.

## Interface
- WIDTH, 8: posit word width; table depth is 2^WIDTH.
- ES, 1: posit exponent size; carried for NaR/zero encoding checks only.
- NUM_FUNCS, 4: number of independent tables; FW = max(1, clog2(NUM_FUNCS)).
- clock  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  unit can accept a lookup this cycle.
- in_func  in  FW  table select.
- in_data  in  WIDTH  posit operand (table address).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  posit result.
- out_func  out  FW  table select that produced out_data.
- load_valid  in  1  table write strobe.
- load_func  in  FW  table to write.
- load_addr  in  WIDTH  entry index.
- load_data  in  WIDTH  entry value.
- func_loaded  out  NUM_FUNCS  bit f set once entry 2^WIDTH-1 of table f is written.

## Operation
- Storage: NUM_FUNCS × 2^WIDTH × WIDTH synchronous-read RAM. Contents are not reset and are undefined until written.
- Write: load_valid writes mem[load_func][load_addr] = load_data. A write is accepted every cycle, independent of lookup traffic and stalls.
- Stage S0 register: captures {func, data, nar_flag} on an accepted lookup (in_valid && in_ready).
- RAM read is issued from S0.
- Stage S1 register: holds the read result and forwards func and nar_flag.
- NaR bypass: an operand of 1 followed by WIDTH-1 zeros always returns NaR, regardless of table contents.
- All other operands, including zero, return the table entry.
- Out-of-range function select: when in_func ≥ NUM_FUNCS, the lookup returns NaR.
- Read/write collision: a write and a read to the same table and address in the same cycle returns the OLD value (read-before-write). The new value is seen by the next read.
- func_loaded: sticky per function. It is cleared only by reset and is not cleared by further writes.

## Timing
- Reset values: in_ready=1 only after reset deasserts (0 while resetn=0), out_valid=0, out_data=0, out_func=0, func_loaded=0, S0/S1 valid=0.
- Latency: accept at edge N → out_valid at edge N+2. Throughput is 1/cycle while out_ready=1.
- stall = out_valid && !out_ready.
- in_ready = !stall.
- During a stall, S0, S1 and the RAM read-enable all freeze. out_data/out_func hold stable while out_valid=1 && !out_ready.
- Bubbles are not compressed: a stall freezes an empty S0 as well.
- Writes during a stall are allowed.
  - A frozen S1 result is not re-read, so it keeps the pre-write value.
  - A frozen S0 entry whose read has not yet been issued reads the post-write value.
- Reset mid-operation: all in-flight lookups are discarded and func_loaded is cleared. RAM contents are unspecified after reset; the bench must reload.
- Simultaneous in_valid and load_valid to any address: both are accepted, with collision handled per Operation.

## Test plan
- Load table 0 with identity (mem[a]=a) and table 1 with mem[a]=~a. Stream in_data 0x00..0xFF on func 0 then func 1 with out_ready=1 → one result/cycle, 2-cycle latency, outputs a then ~a except in_data=0x80 → 0x80. func_loaded=4'b0011.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → in_ready=0 in the same cycles, out_data frozen, no result lost or duplicated, order preserved.
- Collision: mem[2][0x10]=0x22. In the same cycle, load 0x55 to that address and look up func 2 / data 0x10 → 0x22. Next lookup → 0x55.
- NaR and out-of-range: load table 3 with all 0x11 → data 0x80 returns 0x80 and data 0x00 returns 0x11. With NUM_FUNCS=3, func 3 → 0x80.
- Reset mid-stream: assert resetn=0 with 2 lookups in flight → out_valid=0 immediately, func_loaded=0, and no stale result appears after release.
- Parameter sweep: WIDTH=6/ES=0, NUM_FUNCS=1 (FW=1) → identity-table test passes.
